// File: rtl/uart_rx_if.sv
// Parallel side and line of the UART receiver: serial input, per-frame config, received data
// and the three one-cycle status pulses.
interface uart_rx_if #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PRESCALE_WD = 6
);
  logic                   rx_in;
  logic                   par_en;
  logic                   par_typ;
  logic [PRESCALE_WD-1:0] prescale;
  logic [WIDTH-1:0]       p_data;
  logic                   data_valid;
  logic                   par_err;
  logic                   stp_err;

  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 3-sample mid-bit majority vote, optional parity, stop-bit check,
// WIDTH-bit parallel output with single-cycle valid / error pulses.
module uart_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PRESCALE_WD = 6
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PRESCALE_WD-1:0] EdgeOne = PRESCALE_WD'(1);
  localparam logic [PRESCALE_WD-1:0] EdgeTwo = PRESCALE_WD'(2);
  localparam logic [BitW-1:0] BitOne  = BitW'(1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q;
  logic                   sync1_q, rx_s_q;
  logic                   armed_q;
  logic [PRESCALE_WD-1:0] edge_cnt_q, presc_q;
  logic [BitW-1:0]        bit_cnt_q;
  logic                   par_en_q, par_typ_q;
  logic [2:0]             samp_q;
  logic [WIDTH-1:0]       shift_q, p_data_q;
  logic                   dv_q, pe_q, se_q;

  logic [PRESCALE_WD-1:0] half;
  logic                   at_s0, at_s1, at_s2, at_res, at_end;
  logic                   maj, exp_par;

  assign half    = presc_q >> 1;
  assign at_s0   = (edge_cnt_q == half - EdgeOne);
  assign at_s1   = (edge_cnt_q == half);
  assign at_s2   = (edge_cnt_q == half + EdgeOne);
  assign at_res  = (edge_cnt_q == half + EdgeTwo);
  assign at_end  = (edge_cnt_q == presc_q - EdgeOne);
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign exp_par = (^shift_q) ^ par_typ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      armed_q    <= 1'b0;
      edge_cnt_q <= '0;
      presc_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      sync1_q <= bus.rx_in;
      rx_s_q  <= sync1_q;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;

      if (state_q != StIdle) begin
        edge_cnt_q <= at_end ? '0 : edge_cnt_q + EdgeOne;
        if (at_s0) samp_q[0] <= rx_s_q;
        if (at_s1) samp_q[1] <= rx_s_q;
        if (at_s2) samp_q[2] <= rx_s_q;
      end

      unique case (state_q)
        StIdle: begin
          edge_cnt_q <= '0;
          if (!rx_s_q && armed_q) begin
            // The detect cycle itself counts as edge 0 of the start bit.
            state_q    <= StStart;
            armed_q    <= 1'b0;
            edge_cnt_q <= EdgeOne;
            presc_q    <= bus.prescale;
            par_en_q   <= bus.par_en;
            par_typ_q  <= bus.par_typ;
          end else if (rx_s_q) begin
            armed_q <= 1'b1;
          end
        end
        StStart: begin
          if (at_res && maj) begin
            state_q <= StIdle;
          end else if (at_end) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (at_res) shift_q[bit_cnt_q] <= maj;
          if (at_end) begin
            if (bit_cnt_q == BitLast) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitOne;
            end
          end
        end
        StParity: begin
          if (at_res && (maj != exp_par)) begin
            pe_q    <= 1'b1;
            state_q <= StIdle;
          end else if (at_end) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          // Leave at mid-bit so a back-to-back start edge is seen with margin.
          if (at_res) begin
            if (maj) begin
              p_data_q <= shift_q;
              dv_q     <= 1'b1;
            end else begin
              se_q <= 1'b1;
            end
            state_q <= StIdle;
          end else if (at_end) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stp_err    = se_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a per-cycle line waveform, derives expected pulses from a frame-level
// model of the line, and checks every output on every cycle plus a few literal anchors.
module tb_uart_rx;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 6;
  localparam int N = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if #(.WIDTH(W), .PRESCALE_WD(PW)) bus ();
  uart_rx #(.WIDTH(W), .PRESCALE_WD(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Stimulus per cycle: value driven just after posedge c.
  bit         line_a [N];
  bit         rst_a  [N];
  bit         pe_a   [N];
  bit         pt_a   [N];
  int         pre_a  [N];
  // Expected outputs visible after posedge c.
  bit         exp_dv [N];
  bit         exp_pe [N];
  bit         exp_se [N];
  logic [7:0] ev_data[N];
  logic [7:0] exp_pd [N];

  int         snap_c [16];
  logic [7:0] snap_v [16];
  int         n_snap;

  int wr_j, n_cyc, cur_p;
  bit cur_pe, cur_pt;
  int n_cmp, n_err;
  int dv_cnt, pe_cnt, se_cnt;
  int t1_j0, t6_j0, t1_dv;

  task automatic put(input bit v);
    if (wr_j >= N) begin
      $display("FAIL stimulus_overflow: index %0d exceeds %0d", wr_j, N);
      $fatal(1);
    end
    line_a[wr_j] = v;
    pre_a[wr_j]  = cur_p;
    pe_a[wr_j]   = cur_pe;
    pt_a[wr_j]   = cur_pt;
    wr_j++;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b1);
  endtask

  task automatic snap(input logic [7:0] v);
    snap_c[n_snap] = wr_j;
    snap_v[n_snap] = v;
    n_snap++;
  endtask

  // noise flips one of the three mid-bit samples on each bit; scramble changes config mid-frame.
  task automatic frame(input logic [7:0] d, input bit par_flip, input bit stop_v,
                       input bit noise, input bit scramble);
    bit bits [11];
    int nb, p;
    bit spe, spt, v;
    p = cur_p; spe = cur_pe; spt = cur_pt;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (cur_pe) begin
      bits[nb] = (^d) ^ cur_pt ^ par_flip;
      nb++;
    end
    bits[nb] = stop_v;
    nb++;
    for (int k = 0; k < nb; k++) begin
      if (scramble && k == 1) begin
        cur_p = 32; cur_pe = ~spe; cur_pt = ~spt;
      end
      for (int e = 0; e < p; e++) begin
        v = bits[k];
        if (noise && e == p / 2 - 1 + k % 3) v = ~v;
        put(v);
      end
    end
    cur_p = p; cur_pe = spe; cur_pt = spt;
  endtask

  function automatic bit bitv(input int j0, input int p, input int k);
    int s;
    s = j0 + k * p + p / 2 - 1;
    return (line_a[s] & line_a[s+1]) | (line_a[s] & line_a[s+2]) | (line_a[s+1] & line_a[s+2]);
  endfunction

  // Line-level model: a frame starts on the first low line cycle while armed; its outcome appears
  // 2 sync cycles + 1 detect cycle + k*P + P/2+2 later, where k is the deciding bit.
  task automatic run_model();
    int j, j0, p, k, kind, rc, fx;
    bit armed, pe, pt;
    logic [7:0] d, pd;
    j = 0; armed = 1'b0;
    while (j < n_cyc) begin
      if (rst_a[j]) begin
        armed = 1'b1;  // sync flops reset high, so the receiver re-arms on release
        j++;
      end else if (!armed || line_a[j]) begin
        if (line_a[j]) armed = 1'b1;
        j++;
      end else begin
        j0 = j; p = pre_a[j0+2]; pe = pe_a[j0+2]; pt = pt_a[j0+2];
        d = '0; kind = 0; k = 0;
        if (!bitv(j0, p, 0)) begin
          for (int i = 0; i < 8; i++) d[i] = bitv(j0, p, i + 1);
          k = 9;
          if (pe && (bitv(j0, p, 9) != ((^d) ^ pt))) kind = 2;
          else begin
            k = 9 + int'(pe);
            kind = bitv(j0, p, k) ? 1 : 3;
          end
        end
        rc = j0 + k * p + p / 2 + 5;
        fx = -1;
        for (int x = j0; x < rc && fx < 0; x++) if (rst_a[x]) fx = x;
        if (fx >= 0) j = fx;
        else begin
          if (kind == 1) begin exp_dv[rc] = 1'b1; ev_data[rc] = d; end
          if (kind == 2) exp_pe[rc] = 1'b1;
          if (kind == 3) exp_se[rc] = 1'b1;
          j = rc - 2;
          armed = 1'b0;
        end
      end
    end
    pd = '0;
    for (int c = 0; c < n_cyc; c++) begin
      if (c == 0 || rst_a[c-1]) pd = '0;
      if (exp_dv[c]) pd = ev_data[c];
      exp_pd[c] = pd;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; dv_cnt = 0; pe_cnt = 0; se_cnt = 0;
    wr_j = 0; n_snap = 0;
    cur_p = 8; cur_pe = 1'b0; cur_pt = 1'b0;
    bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.par_typ = 1'b0; bus.prescale = PW'(8);

    idle(20); snap(8'h00);
    t1_j0 = wr_j; frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1); idle(20); snap(8'hA5);
    cur_p = 16; cur_pe = 1'b1; cur_pt = 1'b0;
    frame(8'h03, 1'b0, 1'b1, 1'b0, 1'b0); idle(20); snap(8'h03);
    frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0); idle(20); snap(8'h03);
    cur_pt = 1'b1;
    frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40 * 16) put(1'b0);
    idle(32); snap(8'h03);
    frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0); idle(20); snap(8'h81);
    cur_p = 8; cur_pe = 1'b0; cur_pt = 1'b0;
    repeat (3) put(1'b0);
    idle(10);
    frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0); idle(20); snap(8'h5A);
    cur_p = 32;
    frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0); idle(20); snap(8'hFF);
    cur_p = 16;
    frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    t6_j0 = wr_j;
    frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rst_a[t6_j0 + 5 * 16 + 8 + i] = 1'b1;
    idle(40); snap(8'h00);
    frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0); idle(40); snap(8'h3C);
    idle(5);
    for (int i = 0; i < 4; i++) rst_a[i] = 1'b1;
    n_cyc = wr_j;
    run_model();

    fork
      begin
        for (int c = 0; c < n_cyc; c++) begin
          @(posedge clk);
          #1;
          bus.rx_in    = line_a[c];
          rst          = rst_a[c];
          bus.prescale = PW'(pre_a[c]);
          bus.par_en   = pe_a[c];
          bus.par_typ  = pt_a[c];
        end
      end
      begin
        for (int c = 0; c < n_cyc; c++) begin
          @(negedge clk);
          if (c >= 1) begin
            n_cmp++;
            if ({bus.data_valid, bus.par_err, bus.stp_err, bus.p_data} !==
                {exp_dv[c], exp_pe[c], exp_se[c], exp_pd[c]}) begin
              n_err++;
              $display("FAIL cycle_%0d outputs: got dv=%b pe=%b se=%b data=%h, want dv=%b pe=%b se=%b data=%h",
                       c, bus.data_valid, bus.par_err, bus.stp_err, bus.p_data,
                       exp_dv[c], exp_pe[c], exp_se[c], exp_pd[c]);
            end
            if (bus.data_valid === 1'b1) dv_cnt++;
            if (bus.par_err === 1'b1) pe_cnt++;
            if (bus.stp_err === 1'b1) se_cnt++;
          end
          for (int s = 0; s < n_snap; s++) begin
            if (c == snap_c[s]) begin
              n_cmp++;
              if (bus.p_data !== snap_v[s]) begin
                n_err++;
                $display("FAIL p_data_snapshot_%0d: got %h want %h", s, bus.p_data, snap_v[s]);
              end
            end
          end
        end
      end
    join

    // First frame: P=8, no parity -> 9*8+6 after start detect, plus 2 sync + 1 detect cycle.
    t1_dv = -1;
    for (int c = t1_j0; c < n_cyc && t1_dv < 0; c++) if (exp_dv[c]) t1_dv = c;
    n_cmp++;
    if (t1_dv != t1_j0 + 81) begin
      n_err++;
      $display("FAIL model_latency_p8: got cycle %0d want %0d", t1_dv, t1_j0 + 81);
    end
    n_cmp++;
    if (dv_cnt != 8) begin
      n_err++;
      $display("FAIL data_valid_count: got %0d want 8", dv_cnt);
    end
    n_cmp++;
    if (pe_cnt != 1) begin
      n_err++;
      $display("FAIL par_err_count: got %0d want 1", pe_cnt);
    end
    n_cmp++;
    if (se_cnt != 1) begin
      n_err++;
      $display("FAIL stp_err_count: got %0d want 1", se_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
